// File: rtl/display_varredura.sv
`default_nettype none
// display_varredura: scans N multiplexed 7-segment digits from a packed code word,
// with prescaler, guard interval, hex glyphs, leading-zero blanking and decimal points. Rev 1.0
module display_varredura #(
   parameter int N_DIGITOS   = 4,
   parameter int DIV_VARRED  = 50000,
   parameter int GUARD       = 2,
   parameter int MODO_HEX    = 0,
   parameter int ATIVO_BAIXO = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [4*N_DIGITOS-1:0]   entrada,
   input  logic [N_DIGITOS-1:0]     pontos,
   input  logic                     carrega,
   input  logic                     apagar_zeros,
   input  logic                     habilita,
   output logic [6:0]               saida,
   output logic                     ponto,
   output logic [N_DIGITOS-1:0]     anodo,
   output logic                     fim_varredura
);
   localparam int PW = (DIV_VARRED > 2) ? $clog2(DIV_VARRED) : 1;
   localparam int IW = $clog2(N_DIGITOS);
   localparam logic [PW-1:0] TERMINAL   = PW'(DIV_VARRED - 1);
   localparam logic [PW-1:0] FIM_GUARDA = PW'(GUARD);
   localparam logic [IW-1:0] ULTIMO     = IW'(N_DIGITOS - 1);
   localparam logic          INV        = (ATIVO_BAIXO != 0);

   localparam logic [0:0] GUARDA = 1'b0;
   localparam logic [0:0] ATIVO  = 1'b1;

   logic [4*N_DIGITOS-1:0] sombra_dig;
   logic [N_DIGITOS-1:0]   sombra_pt;
   logic [PW-1:0]          presc;
   logic [IW-1:0]          idx;
   logic                   volta;
   logic [0:0]             estado;
   logic                   zeros_acima;
   logic [N_DIGITOS-1:0]   apaga;
   logic [3:0]             digito;
   logic                   pt_sel;
   logic                   apaga_sel;
   logic [N_DIGITOS-1:0]   sel;
   logic                   mostra;
   logic [6:0]             seg_prox;
   logic                   pt_prox;
   logic [N_DIGITOS-1:0]   an_prox;
   logic                   fim_prox;

   function automatic logic [6:0] decodifica(input logic [3:0] c);
      logic [6:0] g;
      g = 7'b0000000;
      case (c)
         4'h0: g = 7'b1111110;
         4'h1: g = 7'b0110000;
         4'h2: g = 7'b1101101;
         4'h3: g = 7'b1111001;
         4'h4: g = 7'b0110011;
         4'h5: g = 7'b1011011;
         4'h6: g = 7'b1011111;
         4'h7: g = 7'b1110000;
         4'h8: g = 7'b1111111;
         4'h9: g = 7'b1110011;
         4'hA: g = (MODO_HEX != 0) ? 7'b1110111 : 7'b0000000;
         4'hB: g = (MODO_HEX != 0) ? 7'b0011111 : 7'b0000000;
         4'hC: g = (MODO_HEX != 0) ? 7'b1001110 : 7'b0000000;
         4'hD: g = (MODO_HEX != 0) ? 7'b0111101 : 7'b0000000;
         4'hE: g = (MODO_HEX != 0) ? 7'b1001111 : 7'b0000000;
         default: g = (MODO_HEX != 0) ? 7'b1000111 : 7'b0000000;
      endcase
      return g;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sombra_dig <= '0;
         sombra_pt  <= '0;
      end else if (carrega) begin
         sombra_dig <= entrada;
         sombra_pt  <= pontos;
      end
   end

   // Leading zeros: digit i>0 blanks when it and all digits above it are zero.
   always_comb begin
      zeros_acima = apagar_zeros;
      apaga       = '0;
      for (int i = N_DIGITOS - 1; i > 0; i--) begin
         zeros_acima = zeros_acima & (sombra_dig[4*i +: 4] == 4'd0);
         apaga[i]    = zeros_acima;
      end
   end

   always_comb begin
      digito    = 4'd0;
      pt_sel    = 1'b0;
      apaga_sel = 1'b0;
      sel       = '0;
      for (int i = 0; i < N_DIGITOS; i++) begin
         if (idx == IW'(i)) begin
            digito    = sombra_dig[4*i +: 4];
            pt_sel    = sombra_pt[i];
            apaga_sel = apaga[i];
            sel[i]    = 1'b1;
         end
      end
      estado   = (presc < FIM_GUARDA) ? GUARDA : ATIVO;
      mostra   = habilita && (estado == ATIVO);
      seg_prox = (mostra && !apaga_sel) ? decodifica(digito) : 7'b0000000;
      pt_prox  = mostra && pt_sel;
      an_prox  = mostra ? sel : '0;
      fim_prox = habilita && (presc == '0) && (idx == '0) && volta;
   end

   // volta marks the wrap out of the last digit so the next slot-0 entry raises fim.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc <= '0;
         idx   <= '0;
         volta <= 1'b0;
      end else if (!habilita) begin
         presc <= '0;
         idx   <= '0;
         volta <= 1'b0;
      end else if (presc == TERMINAL) begin
         presc <= '0;
         idx   <= (idx == ULTIMO) ? '0 : idx + 1'b1;
         volta <= (idx == ULTIMO);
      end else begin
         presc <= presc + 1'b1;
         volta <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         saida         <= {7{INV}};
         ponto         <= INV;
         anodo         <= {N_DIGITOS{INV}};
         fim_varredura <= 1'b0;
      end else begin
         saida         <= seg_prox ^ {7{INV}};
         ponto         <= pt_prox ^ INV;
         anodo         <= an_prox ^ {N_DIGITOS{INV}};
         fim_varredura <= fim_prox;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_display_varredura.sv
`default_nettype none
// tb_display_varredura: directed scoreboard bench, two DUTs (MODO_HEX 0 and 1) on shared inputs.
module tb_display_varredura;
   localparam logic [6:0] G0 = 7'b1111110;
   localparam logic [6:0] G1 = 7'b0110000;
   localparam logic [6:0] G2 = 7'b1101101;
   localparam logic [6:0] G3 = 7'b1111001;
   localparam logic [6:0] G4 = 7'b0110011;
   localparam logic [6:0] G5 = 7'b1011011;
   localparam logic [6:0] G9 = 7'b1110011;
   localparam logic [6:0] GA = 7'b1110111;
   localparam logic [6:0] BL = 7'b0000000;

   logic        clk;
   logic        rst;
   logic [15:0] entrada;
   logic [3:0]  pontos;
   logic        carrega;
   logic        apagar;
   logic        habilita;
   logic [6:0]  saida0, saida1;
   logic        ponto0, ponto1;
   logic [3:0]  anodo0, anodo1;
   logic        fim0, fim1;

   typedef struct {
      logic [3:0] an;
      logic [6:0] s0;
      logic [6:0] s1;
      logic       pt;
      logic       fim;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   display_varredura #(.N_DIGITOS(4), .DIV_VARRED(4), .GUARD(1), .MODO_HEX(0), .ATIVO_BAIXO(1)) dut0 (
      .clk(clk), .reset(rst), .entrada(entrada), .pontos(pontos), .carrega(carrega),
      .apagar_zeros(apagar), .habilita(habilita), .saida(saida0), .ponto(ponto0),
      .anodo(anodo0), .fim_varredura(fim0));

   display_varredura #(.N_DIGITOS(4), .DIV_VARRED(4), .GUARD(1), .MODO_HEX(1), .ATIVO_BAIXO(1)) dut1 (
      .clk(clk), .reset(rst), .entrada(entrada), .pontos(pontos), .carrega(carrega),
      .apagar_zeros(apagar), .habilita(habilita), .saida(saida1), .ponto(ponto1),
      .anodo(anodo1), .fim_varredura(fim1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
      end
   endtask

   // Monitor: every output cycle with a pending expectation is compared.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("anodo_hex0", {4'b0, anodo0}, {4'b0, e.an});
            chk("anodo_hex1", {4'b0, anodo1}, {4'b0, e.an});
            chk("saida_hex0", {1'b0, saida0}, {1'b0, e.s0});
            chk("saida_hex1", {1'b0, saida1}, {1'b0, e.s1});
            chk("ponto_hex0", {7'b0, ponto0}, {7'b0, e.pt});
            chk("ponto_hex1", {7'b0, ponto1}, {7'b0, e.pt});
            chk("fim_hex0",   {7'b0, fim0},   {7'b0, e.fim});
            chk("fim_hex1",   {7'b0, fim1},   {7'b0, e.fim});
         end
      end
   end

   task automatic cyc(input logic [3:0] an, input logic [6:0] s0, input logic [6:0] s1,
                      input logic pt, input logic fim);
      exp_t e;
      @(posedge clk);
      #1;
      e.an = an; e.s0 = s0; e.s1 = s1; e.pt = pt; e.fim = fim;
      q.push_back(e);
   endtask

   task automatic idle();
      cyc(4'hF, 7'h7F, 7'h7F, 1'b1, 1'b0);
   endtask

   // One slot: guard cycle then three active cycles; glyphs given in active-high form.
   task automatic slot(input int i, input logic [6:0] g0, input logic [6:0] g1,
                       input logic pt, input logic fim);
      logic [3:0] an_v;
      an_v = 4'b0001 << i;
      an_v = ~an_v;
      cyc(4'hF, 7'h7F, 7'h7F, 1'b1, fim);
      carrega = 1'b0;
      repeat (3) cyc(an_v, ~g0, ~g1, ~pt, 1'b0);
   endtask

   initial begin
      exp_t e;
      rst = 1'b1; entrada = 16'h1234; pontos = 4'b0000; carrega = 1'b1;
      apagar = 1'b0; habilita = 1'b1;
      idle();
      idle();
      rst = 1'b0;

      // Plain scans of 1234, no blanking
      slot(0, G4, G4, 1'b0, 1'b0); slot(1, G3, G3, 1'b0, 1'b0);
      slot(2, G2, G2, 1'b0, 1'b0); slot(3, G1, G1, 1'b0, 1'b0);
      slot(0, G4, G4, 1'b0, 1'b1); slot(1, G3, G3, 1'b0, 1'b0);
      slot(2, G2, G2, 1'b0, 1'b0); slot(3, G1, G1, 1'b0, 1'b0);

      // 00A5 with leading-zero blanking; code A blank unless hex glyphs enabled
      entrada = 16'h00A5; apagar = 1'b1; carrega = 1'b1;
      slot(0, G5, G5, 1'b0, 1'b1); slot(1, BL, GA, 1'b0, 1'b0);
      slot(2, BL, BL, 1'b0, 1'b0); slot(3, BL, BL, 1'b0, 1'b0);

      // all zeros: only digit 0 lit, decimal point on blanked digit 2
      entrada = 16'h0000; pontos = 4'b0100; carrega = 1'b1;
      slot(0, G0, G0, 1'b0, 1'b1); slot(1, BL, BL, 1'b0, 1'b0);
      slot(2, BL, BL, 1'b1, 1'b0); slot(3, BL, BL, 1'b0, 1'b0);

      // mid-slot load of 9999
      slot(0, G0, G0, 1'b0, 1'b1);
      cyc(4'hF, 7'h7F, 7'h7F, 1'b1, 1'b0);
      cyc(4'hD, 7'h7F, 7'h7F, 1'b1, 1'b0);
      entrada = 16'h9999; pontos = 4'b0000; carrega = 1'b1;
      cyc(4'hD, 7'h7F, 7'h7F, 1'b1, 1'b0);
      carrega = 1'b0;
      cyc(4'hD, ~G9, ~G9, 1'b1, 1'b0);
      slot(2, G9, G9, 1'b0, 1'b0); slot(3, G9, G9, 1'b0, 1'b0);

      // disable for 5 cycles, then restart at slot 0 without fim
      habilita = 1'b0;
      repeat (5) idle();
      habilita = 1'b1;
      slot(0, G9, G9, 1'b0, 1'b0); slot(1, G9, G9, 1'b0, 1'b0);

      // reset asserted asynchronously in the middle of slot 2
      cyc(4'hF, 7'h7F, 7'h7F, 1'b1, 1'b0);
      cyc(4'hB, ~G9, ~G9, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      e.an = 4'hF; e.s0 = 7'h7F; e.s1 = 7'h7F; e.pt = 1'b1; e.fim = 1'b0;
      q.push_back(e);
      #1 rst = 1'b1;
      idle();
      idle();
      rst = 1'b0;
      slot(0, G0, G0, 1'b0, 1'b0); slot(1, BL, BL, 1'b0, 1'b0);
      slot(2, BL, BL, 1'b0, 1'b0); slot(3, BL, BL, 1'b0, 1'b0);
      slot(0, G0, G0, 1'b0, 1'b1);

      @(negedge clk);
      #1;
      chk("fila_vazia", 8'(q.size()), 8'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
